// File: rtl/adder_accumulator_ctrl.sv
// ---------------------------------------------------------------------------
// adder_accumulator_ctrl
//
// Feeds an external 4-bit full adder from registers, waits a programmable
// settle interval, then captures the adder result into a 4-bit accumulator
// and updates the carry / overflow / zero flags. One operation is in flight
// at a time, offered on a valid/ready handshake.
//
// Parameters
//   SETTLE_CYCLES  cycles the adder inputs are held before capture (1..4)
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   in_valid       operation offered
//   in_ready       block can accept an operation (registered)
//   op             00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//   operand        4-bit operand of the offered operation
//   add_a/add_b    adder operand inputs (registered)
//   add_cin        adder carry-in (registered)
//   add_sum        adder sum output
//   add_cout       adder carry-out
//   acc            accumulator value
//   carry_flag     ADD carry-out, or SUB no-borrow
//   overflow_flag  two's-complement overflow of the last ADD/SUB
//   zero_flag      acc == 0
//   out_valid      one-cycle pulse in the cycle a result becomes visible
// ---------------------------------------------------------------------------
// state  | meaning
// IDLE   | in_ready high, waiting for an operation
// EXEC   | adder inputs held, settle counter running; commit when it hits 0
// DONE   | out_valid pulse, result already visible; back to IDLE next cycle
// ---------------------------------------------------------------------------
module adder_accumulator_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] op,
   input  logic [3:0] operand,
   output logic [3:0] add_a,
   output logic [3:0] add_b,
   output logic       add_cin,
   input  logic [3:0] add_sum,
   input  logic       add_cout,
   output logic [3:0] acc,
   output logic       carry_flag,
   output logic       overflow_flag,
   output logic       zero_flag,
   output logic       out_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   // Counter holds SETTLE_CYCLES-1 at most, i.e. 0..3 for the legal range.
   localparam logic [1:0] CNT_LOAD = 2'(SETTLE_CYCLES - 1);

   state_t     state_q,     state_d;
   logic [1:0] cnt_q,       cnt_d;
   logic [1:0] op_q,        op_d;
   logic [3:0] operand_q,   operand_d;
   logic [3:0] add_a_q,     add_a_d;
   logic [3:0] add_b_q,     add_b_d;
   logic       add_cin_q,   add_cin_d;
   logic [3:0] acc_q,       acc_d;
   logic       carry_q,     carry_d;
   logic       overflow_q,  overflow_d;
   logic       zero_q,      zero_d;
   logic       in_ready_q,  in_ready_d;

   logic       accept;
   logic [3:0] commit_acc;
   logic       commit_carry;
   logic       commit_overflow;

   assign accept = in_valid & in_ready_q & (state_q == S_IDLE);

   // Result that would be committed this cycle, based on the latched op.
   // Overflow uses the registered adder inputs, so for SUB the inverted
   // operand is what gets compared.
   always_comb begin
      commit_acc      = 4'd0;
      commit_carry    = 1'b0;
      commit_overflow = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            commit_acc      = add_sum;
            commit_carry    = add_cout;
            commit_overflow = (add_a_q[3] == add_b_q[3]) & (add_sum[3] != add_a_q[3]);
         end
         OP_LOAD: begin
            commit_acc = operand_q;
         end
         OP_CLEAR: begin
            commit_acc = 4'd0;
         end
         default: begin
            commit_acc = 4'd0;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      operand_d  = operand_q;
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      add_cin_d  = add_cin_q;
      acc_d      = acc_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d      = op;
               operand_d = operand;
               add_a_d   = acc_q;
               // LOAD and CLEAR do not use the adder, so b/cin keep their
               // previous values.
               if (op == OP_ADD) begin
                  add_b_d   = operand;
                  add_cin_d = 1'b0;
               end else if (op == OP_SUB) begin
                  add_b_d   = ~operand;
                  add_cin_d = 1'b1;
               end
               cnt_d   = CNT_LOAD;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cnt_q == 2'd0) begin
               acc_d      = commit_acc;
               carry_d    = commit_carry;
               overflow_d = commit_overflow;
               zero_d     = (commit_acc == 4'd0);
               state_d    = S_DONE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered copy of "next state is IDLE" so in_ready is low during
      // reset and rises only on the first edge with rst released.
      in_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 2'd0;
         op_q       <= OP_ADD;
         operand_q  <= 4'd0;
         add_a_q    <= 4'd0;
         add_b_q    <= 4'd0;
         add_cin_q  <= 1'b0;
         acc_q      <= 4'd0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b1;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         operand_q  <= operand_d;
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         add_cin_q  <= add_cin_d;
         acc_q      <= acc_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = (state_q == S_DONE);
   assign add_a         = add_a_q;
   assign add_b         = add_b_q;
   assign add_cin       = add_cin_q;
   assign acc           = acc_q;
   assign carry_flag    = carry_q;
   assign overflow_flag = overflow_q;
   assign zero_flag     = zero_q;

endmodule

// File: tb/tb_adder_accumulator_ctrl.sv
module tb_adder_accumulator_ctrl;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DUT with SETTLE_CYCLES = 1
   logic       in_valid1 = 1'b0;
   logic       in_ready1;
   logic [1:0] op1 = 2'b00;
   logic [3:0] operand1 = 4'd0;
   logic [3:0] add_a1, add_b1, add_sum1, acc1;
   logic       add_cin1, add_cout1, carry1, ovf1, zero1, out_valid1;
   logic [4:0] s1;
   logic [2:0] flags1;
   assign s1 = {1'b0, add_a1} + {1'b0, add_b1} + {4'd0, add_cin1};
   assign add_sum1  = s1[3:0];
   assign add_cout1 = s1[4];
   assign flags1 = {carry1, ovf1, zero1};

   // DUT with SETTLE_CYCLES = 3
   logic       in_valid3 = 1'b0;
   logic       in_ready3;
   logic [1:0] op3 = 2'b00;
   logic [3:0] operand3 = 4'd0;
   logic [3:0] add_a3, add_b3, add_sum3, acc3;
   logic       add_cin3, add_cout3, carry3, ovf3, zero3, out_valid3;
   logic [4:0] s3;
   assign s3 = {1'b0, add_a3} + {1'b0, add_b3} + {4'd0, add_cin3};
   assign add_sum3  = s3[3:0];
   assign add_cout3 = s3[4];

   adder_accumulator_ctrl #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .op(op1), .operand(operand1), .add_a(add_a1), .add_b(add_b1),
      .add_cin(add_cin1), .add_sum(add_sum1), .add_cout(add_cout1),
      .acc(acc1), .carry_flag(carry1), .overflow_flag(ovf1),
      .zero_flag(zero1), .out_valid(out_valid1));

   adder_accumulator_ctrl #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
      .op(op3), .operand(operand3), .add_a(add_a3), .add_b(add_b3),
      .add_cin(add_cin3), .add_sum(add_sum3), .add_cout(add_cout3),
      .acc(acc3), .carry_flag(carry3), .overflow_flag(ovf3),
      .zero_flag(zero3), .out_valid(out_valid3));

   // Stimulus drivers: offer one op, return cycles from accept edge to the
   // out_valid cycle (-1 if it never came).
   task automatic run_op1(input logic [1:0] o, input logic [3:0] v, output int lat);
      int n = 0;
      @(negedge clk);
      while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
      in_valid1 = 1'b1; op1 = o; operand1 = v;
      @(posedge clk); #1 in_valid1 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (out_valid1) begin lat = k; break; end
      end
   endtask

   task automatic run_op3(input logic [1:0] o, input logic [3:0] v, output int lat);
      int n = 0;
      @(negedge clk);
      while (!in_ready3 && n < 20) begin @(negedge clk); n++; end
      in_valid3 = 1'b1; op3 = o; operand3 = v;
      @(posedge clk); #1 in_valid3 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (out_valid3) begin lat = k; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (acc1 !== 4'd0) begin errors++; $display("FAIL reset_acc got %0d expected 0", acc1); end
      checks++; if (flags1 !== 3'b001) begin errors++; $display("FAIL reset_flags got %b expected 001", flags1); end
      checks++; if ({add_a1, add_b1, add_cin1} !== 9'd0) begin errors++; $display("FAIL reset_add got %h expected 0", {add_a1, add_b1, add_cin1}); end
      checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready_during_rst got %b expected 0", in_ready1); end
      checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid1); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b expected 1", in_ready1); end
      checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL reset_ready3_after got %b expected 1", in_ready3); end
   endtask

   task automatic test_add_wrap();
      int lat;
      run_op1(OP_ADD, 4'd7, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL add7_latency got %0d expected 2", lat); end
      checks++; if (acc1 !== 4'd7) begin errors++; $display("FAIL add7_acc got %0d expected 7", acc1); end
      checks++; if (flags1 !== 3'b000) begin errors++; $display("FAIL add7_flags got %b expected 000", flags1); end
      run_op1(OP_ADD, 4'd9, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL add9_latency got %0d expected 2", lat); end
      checks++; if (acc1 !== 4'd0) begin errors++; $display("FAIL add9_acc got %0d expected 0", acc1); end
      checks++; if (flags1 !== 3'b101) begin errors++; $display("FAIL add9_flags got %b expected 101", flags1); end
      @(negedge clk);
      checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL add9_pulse_width got %b expected 0", out_valid1); end
      checks++; if (acc1 !== 4'd0 || flags1 !== 3'b101) begin errors++; $display("FAIL add9_hold got %0d/%b expected 0/101", acc1, flags1); end
   endtask

   task automatic test_overflow();
      int lat;
      run_op1(OP_LOAD, 4'd5, lat);
      checks++; if (acc1 !== 4'd5 || flags1 !== 3'b000) begin errors++; $display("FAIL load5 got %0d/%b expected 5/000", acc1, flags1); end
      run_op1(OP_ADD, 4'd3, lat);
      checks++; if (acc1 !== 4'd8) begin errors++; $display("FAIL ovf_add3_acc got %0d expected 8", acc1); end
      checks++; if (flags1 !== 3'b010) begin errors++; $display("FAIL ovf_add3_flags got %b expected 010", flags1); end
      run_op1(OP_SUB, 4'd1, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sub1_latency got %0d expected 2", lat); end
      checks++; if (acc1 !== 4'd7) begin errors++; $display("FAIL ovf_sub1_acc got %0d expected 7", acc1); end
      checks++; if (flags1 !== 3'b110) begin errors++; $display("FAIL ovf_sub1_flags got %b expected 110", flags1); end
   endtask

   task automatic test_borrow();
      int lat;
      run_op1(OP_LOAD, 4'd3, lat);
      run_op1(OP_SUB, 4'd5, lat);
      checks++; if (acc1 !== 4'd14) begin errors++; $display("FAIL borrow_acc got %0d expected 14", acc1); end
      checks++; if (flags1 !== 3'b000) begin errors++; $display("FAIL borrow_flags got %b expected 000", flags1); end
      checks++; if (add_b1 !== 4'd10 || add_cin1 !== 1'b1) begin errors++; $display("FAIL borrow_sub_inputs got %0d/%b expected 10/1", add_b1, add_cin1); end
      run_op1(OP_CLEAR, 4'd9, lat);
      checks++; if (acc1 !== 4'd0) begin errors++; $display("FAIL clear_acc got %0d expected 0", acc1); end
      checks++; if (flags1 !== 3'b001) begin errors++; $display("FAIL clear_flags got %b expected 001", flags1); end
   endtask

   task automatic test_busy_reject();
      int lat;
      int n = 0;
      run_op1(OP_CLEAR, 4'd0, lat);
      @(negedge clk);
      while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
      in_valid1 = 1'b1; op1 = OP_ADD; operand1 = 4'd1;
      @(posedge clk); #1 op1 = OP_LOAD; operand1 = 4'd15;
      @(negedge clk);
      checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL busy_exec_ready got %b expected 0", in_ready1); end
      checks++; if (add_a1 !== 4'd0 || add_b1 !== 4'd1 || add_cin1 !== 1'b0) begin errors++; $display("FAIL busy_exec_inputs got %0d/%0d/%b expected 0/1/0", add_a1, add_b1, add_cin1); end
      @(posedge clk); #1 op1 = OP_CLEAR;
      @(negedge clk);
      checks++; if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0) begin errors++; $display("FAIL busy_done got valid %b ready %b expected 1 0", out_valid1, in_ready1); end
      checks++; if (acc1 !== 4'd1) begin errors++; $display("FAIL busy_first_commit got %0d expected 1", acc1); end
      @(posedge clk); #1 op1 = OP_SUB; operand1 = 4'd1;
      @(negedge clk);
      checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || acc1 !== 4'd1) begin errors++; $display("FAIL busy_idle_again got ready %b valid %b acc %0d expected 1 0 1", in_ready1, out_valid1, acc1); end
      @(posedge clk); #1 in_valid1 = 1'b0;
      @(negedge clk);
      checks++; if (add_a1 !== 4'd1 || add_b1 !== 4'd14 || add_cin1 !== 1'b1) begin errors++; $display("FAIL busy_second_inputs got %0d/%0d/%b expected 1/14/1", add_a1, add_b1, add_cin1); end
      @(negedge clk);
      checks++; if (out_valid1 !== 1'b1 || acc1 !== 4'd0 || flags1 !== 3'b101) begin errors++; $display("FAIL busy_second_commit got valid %b acc %0d flags %b expected 1 0 101", out_valid1, acc1, flags1); end
   endtask

   task automatic test_reset_mid_op();
      int lat;
      int n = 0;
      int pulses = 0;
      run_op1(OP_LOAD, 4'd4, lat);
      @(negedge clk);
      while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
      in_valid1 = 1'b1; op1 = OP_ADD; operand1 = 4'd6;
      @(posedge clk); #1 in_valid1 = 1'b0; rst = 1'b1;
      @(negedge clk);
      checks++; if (add_a1 !== 4'd4 || add_b1 !== 4'd6) begin errors++; $display("FAIL midrst_exec_inputs got %0d/%0d expected 4/6", add_a1, add_b1); end
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid1) pulses++;
      checks++; if (acc1 !== 4'd0 || zero1 !== 1'b1) begin errors++; $display("FAIL midrst_acc got %0d zero %b expected 0 1", acc1, zero1); end
      checks++; if ({add_a1, add_b1, add_cin1} !== 9'd0) begin errors++; $display("FAIL midrst_add got %h expected 0", {add_a1, add_b1, add_cin1}); end
      checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b expected 0", in_ready1); end
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (out_valid1) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_out_valid got %0d pulses expected 0", pulses); end
      checks++; if (in_ready1 !== 1'b1 || acc1 !== 4'd0) begin errors++; $display("FAIL midrst_recover got ready %b acc %0d expected 1 0", in_ready1, acc1); end
   endtask

   task automatic test_settle();
      int lat;
      int n = 0;
      run_op3(OP_LOAD, 4'd1, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL settle_load_latency got %0d expected 4", lat); end
      @(negedge clk);
      while (!in_ready3 && n < 20) begin @(negedge clk); n++; end
      in_valid3 = 1'b1; op3 = OP_ADD; operand3 = 4'd2;
      @(posedge clk); #1 in_valid3 = 1'b0; operand3 = 4'd9;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (add_a3 !== 4'd1 || add_b3 !== 4'd2 || add_cin3 !== 1'b0 || in_ready3 !== 1'b0 || out_valid3 !== 1'b0 || acc3 !== 4'd1) begin
            errors++;
            $display("FAIL settle_exec_cycle%0d got a %0d b %0d cin %b ready %b valid %b acc %0d expected 1 2 0 0 0 1",
                     k, add_a3, add_b3, add_cin3, in_ready3, out_valid3, acc3);
         end
      end
      @(negedge clk);
      checks++; if (out_valid3 !== 1'b1 || in_ready3 !== 1'b0) begin errors++; $display("FAIL settle_done got valid %b ready %b expected 1 0", out_valid3, in_ready3); end
      checks++; if (acc3 !== 4'd3 || {carry3, ovf3, zero3} !== 3'b000) begin errors++; $display("FAIL settle_result got %0d/%b expected 3/000", acc3, {carry3, ovf3, zero3}); end
      @(negedge clk);
      checks++; if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0) begin errors++; $display("FAIL settle_ready_back got ready %b valid %b expected 1 0", in_ready3, out_valid3); end
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_overflow();
      test_borrow();
      test_busy_reject();
      test_reset_mid_op();
      test_settle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
